// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit: FSM state encoding, RISC-V
// funct3 access codes and a legality helper used when a request arrives.
// The opcode macros are defined only if the core has not already defined
// them, so the existing OPCODE_LOAD / OPCODE_STORE values are reused.
// ---------------------------------------------------------------------------
`ifndef OPCODE_LOAD
`define OPCODE_LOAD 7'b0000011
`endif
`ifndef OPCODE_STORE
`define OPCODE_STORE 7'b0100011
`endif

package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Stores only know signed sizes; the unsigned codes are load-only.
  function automatic logic f3_legal(input logic wen, input logic [2:0] f3);
    logic sized;
    sized = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    if (wen) begin
      return sized;
    end
    return sized || (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/lsu_mem_align.sv
// ---------------------------------------------------------------------------
// lsu_align
// Purely combinational lane logic for the load/store unit.
// Ports:
//   func3      in  3   access size/sign (RISC-V funct3)
//   offset     in  2   byte offset inside the word (addr[1:0])
//   rdata      in  32  word returned by the bus
//   wdata      in  32  store data (rs2)
//   load_data  out 32  extracted and sign/zero-extended load value
//   wstrb      out 4   byte strobes for a store of this size/offset
//   wdata_rep  out 32  store data replicated across all byte lanes
//   misaligned out 1   halfword at odd address or word not on a 4B boundary
// ---------------------------------------------------------------------------
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic [1:0]  offset,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_rep,
  output logic        misaligned
);

  logic [15:0] lane;

  // The addressed byte/halfword is shifted down to bit 0 first so every
  // extension case reads from the same low lane.
  always_comb begin
    lane = 16'(rdata >> {offset, 3'b000});
    unique case (func3)
      F3_B:    load_data = {{24{lane[7]}}, lane[7:0]};
      F3_BU:   load_data = {24'd0, lane[7:0]};
      F3_H:    load_data = {{16{lane[15]}}, lane};
      F3_HU:   load_data = {16'd0, lane};
      F3_W:    load_data = rdata;
      default: load_data = 32'd0;
    endcase
  end

  // func3[1:0] encodes the size for both loads and stores.
  always_comb begin
    wstrb     = 4'b0000;
    wdata_rep = wdata;
    unique case (func3[1:0])
      2'b00: begin
        wstrb     = 4'b0001 << offset;
        wdata_rep = {4{wdata[7:0]}};
      end
      2'b01: begin
        wstrb     = 4'b0011 << offset;
        wdata_rep = {2{wdata[15:0]}};
      end
      2'b10: begin
        wstrb     = 4'b1111;
        wdata_rep = wdata;
      end
      default: begin
        wstrb     = 4'b0000;
        wdata_rep = wdata;
      end
    endcase
  end

  assign misaligned = ((func3[1:0] == 2'b01) && offset[0]) ||
                      ((func3[1:0] == 2'b10) && (offset != 2'b00));

endmodule

// File: rtl/lsu_mem.sv
// ---------------------------------------------------------------------------
// lsu_mem
// Load/store unit: takes one access from write-back, performs it on a
// valid/ready data bus and returns extended load data or a store ack as a
// single-cycle resp_valid pulse. One transaction outstanding at a time.
// Optional feature macro: LSU_TIMEOUT_EN adds a watchdog in REQ/WAIT that
// ends the access with an error after TIMEOUT_CYCLES cycles.
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   req_valid/req_ready              request handshake from write-back
//   req_wen, req_func3, req_addr,
//   req_wdata                        access description
//   resp_valid, resp_rdata, resp_err completion pulse and result
//   bus_valid/bus_ready              bus request handshake
//   bus_wen, bus_addr, bus_wdata,
//   bus_wstrb                        bus request fields (registered)
//   bus_rsp_valid, bus_rdata,
//   bus_rsp_err                      bus response
// ---------------------------------------------------------------------------
module lsu_mem
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [2:0]  req_func3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic        bus_wen,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_rsp_valid,
  input  logic [31:0] bus_rdata,
  input  logic        bus_rsp_err
);

  lsu_state_t state, state_next;

  logic        wen_q;
  logic [2:0]  func3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [2:0]  align_func3;
  logic [1:0]  align_offset;
  logic [31:0] load_data;
  logic [31:0] wdata_rep;
  logic [3:0]  wstrb;
  logic        misaligned;

  logic accept;
  logic reject;
  logic capture_rsp;
  logic timeout_fire;
  logic timeout_hit;

  // In IDLE the aligner looks at the incoming request (alignment check and
  // store lane data, both captured on accept); afterwards it looks at the
  // latched access so the response can be extracted from bus_rdata.
  assign align_func3  = (state == IDLE) ? req_func3     : func3_q;
  assign align_offset = (state == IDLE) ? req_addr[1:0] : addr_q[1:0];

  lsu_align u_align (
    .func3      (align_func3),
    .offset     (align_offset),
    .rdata      (bus_rdata),
    .wdata      (req_wdata),
    .load_data  (load_data),
    .wstrb      (wstrb),
    .wdata_rep  (wdata_rep),
    .misaligned (misaligned)
  );

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                  $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CNT_W-1:0] timeout_cnt;

  // Held at zero outside REQ/WAIT, so it starts from zero on entry to REQ.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timeout_cnt <= '0;
    end else if ((state == REQ) || (state == WAIT)) begin
      timeout_cnt <= timeout_cnt + CNT_W'(1);
    end else begin
      timeout_cnt <= '0;
    end
  end

  // Fires in the last of TIMEOUT_CYCLES cycles spent in REQ/WAIT.
  assign timeout_hit = (timeout_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A real bus response wins over the watchdog when both land together.
  always_comb begin
    state_next   = state;
    accept       = 1'b0;
    reject       = 1'b0;
    capture_rsp  = 1'b0;
    timeout_fire = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if (!f3_legal(req_wen, req_func3) || misaligned) begin
            reject     = 1'b1;
            state_next = RESP;
          end else begin
            state_next = REQ;
          end
        end
      end
      REQ: begin
        if (bus_ready && bus_rsp_valid) begin
          capture_rsp = 1'b1;
          state_next  = RESP;
        end else if (timeout_hit) begin
          timeout_fire = 1'b1;
          state_next   = RESP;
        end else if (bus_ready) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (bus_rsp_valid) begin
          capture_rsp = 1'b1;
          state_next  = RESP;
        end else if (timeout_hit) begin
          timeout_fire = 1'b1;
          state_next   = RESP;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wen_q   <= 1'b0;
      func3_q <= 3'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      wstrb_q <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        wen_q   <= req_wen;
        func3_q <= req_func3;
        addr_q  <= req_addr;
        wdata_q <= wdata_rep;
        wstrb_q <= req_wen ? wstrb : 4'd0;
        rdata_q <= 32'd0;
        err_q   <= reject;
      end
      if (capture_rsp) begin
        err_q   <= bus_rsp_err;
        rdata_q <= (bus_rsp_err || wen_q) ? 32'd0 : load_data;
      end
      if (timeout_fire) begin
        err_q   <= 1'b1;
        rdata_q <= 32'd0;
      end
    end
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign resp_rdata = (state == RESP) ? rdata_q : 32'd0;
  assign resp_err   = (state == RESP) && err_q;

  assign bus_valid  = (state == REQ);
  assign bus_wen    = wen_q;
  assign bus_addr   = {addr_q[31:2], 2'b00};
  assign bus_wdata  = wdata_q;
  assign bus_wstrb  = wstrb_q;

endmodule

// File: tb/tb_lsu_mem.sv
// ---------------------------------------------------------------------------
// tb_lsu_mem
// Directed bench for lsu_mem. A transaction-level model turns each access
// (size, offset, bus delays) into expected cycle windows and result values;
// one compare process checks the DUT against those windows every cycle.
// ---------------------------------------------------------------------------
module tb_lsu_mem;

`ifdef LSU_TIMEOUT_EN
  localparam int TB_TIMEOUT = 8;
`else
  localparam int TB_TIMEOUT = 255;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [2:0]  req_func3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        bus_valid;
  logic        bus_ready;
  logic        bus_wen;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_rsp_valid;
  logic [31:0] bus_rdata;
  logic        bus_rsp_err;

  lsu_mem #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_wen       (req_wen),
    .req_func3     (req_func3),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .resp_valid    (resp_valid),
    .resp_rdata    (resp_rdata),
    .resp_err      (resp_err),
    .bus_valid     (bus_valid),
    .bus_ready     (bus_ready),
    .bus_wen       (bus_wen),
    .bus_addr      (bus_addr),
    .bus_wdata     (bus_wdata),
    .bus_wstrb     (bus_wstrb),
    .bus_rsp_valid (bus_rsp_valid),
    .bus_rdata     (bus_rdata),
    .bus_rsp_err   (bus_rsp_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  // Model windows (cycle numbers); empty windows use from > to.
  int busy_from = -1, busy_to = -2;
  int bv_from = -1, bv_to = -2;
  int resp_at = -1, zero_chk = -1;
  int ready_cyc = -1, rsp_cyc = -1, stray_cyc = -1;
  logic checking = 1'b0;

  logic [31:0] exp_rdata = '0, exp_addr = '0, exp_wdata = '0;
  logic        exp_err = 1'b0, exp_wen = 1'b0;
  logic [3:0]  exp_wstrb = '0;
  logic [31:0] plan_word = '0;
  logic        plan_err = 1'b0;

  logic        lit_rdata_en = 1'b0, lit_bus_en = 1'b0;
  logic [31:0] lit_rdata = '0, lit_addr = '0, lit_wdata = '0;
  logic [3:0]  lit_wstrb = '0;

  logic e_ready, e_bv, e_resp;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      e_ready = !((cyc >= busy_from) && (cyc <= busy_to));
      e_bv    = (cyc >= bv_from) && (cyc <= bv_to);
      e_resp  = (cyc == resp_at);
      checkOutput("req_ready", 32'(req_ready), 32'(e_ready));
      checkOutput("bus_valid", 32'(bus_valid), 32'(e_bv));
      checkOutput("resp_valid", 32'(resp_valid), 32'(e_resp));
      if (e_resp) begin
        checkOutput("resp_rdata", resp_rdata, exp_rdata);
        checkOutput("resp_err", 32'(resp_err), 32'(exp_err));
        if (lit_rdata_en) checkOutput("lit_rdata", resp_rdata, lit_rdata);
      end
      if (e_bv) begin
        checkOutput("bus_addr", bus_addr, exp_addr);
        checkOutput("bus_wen", 32'(bus_wen), 32'(exp_wen));
        checkOutput("bus_wstrb", 32'(bus_wstrb), 32'(exp_wstrb));
        if (exp_wen) checkOutput("bus_wdata", bus_wdata, exp_wdata);
        if (lit_bus_en) begin
          checkOutput("lit_bus_addr", bus_addr, lit_addr);
          checkOutput("lit_bus_wstrb", 32'(bus_wstrb), 32'(lit_wstrb));
          checkOutput("lit_bus_wdata", bus_wdata, lit_wdata);
        end
      end
      if (cyc == zero_chk) begin
        checkOutput("rst_bus_addr", bus_addr, 32'd0);
        checkOutput("rst_bus_wdata", bus_wdata, 32'd0);
        checkOutput("rst_bus_wstrb", 32'(bus_wstrb), 32'd0);
        checkOutput("rst_bus_wen", 32'(bus_wen), 32'd0);
        checkOutput("rst_resp_rdata", resp_rdata, 32'd0);
        checkOutput("rst_resp_err", 32'(resp_err), 32'd0);
      end
    end
  end

  // Advance one cycle and drive the open-loop bus responder for it.
  task automatic step();
    @(posedge clk);
    #1;
    bus_ready     = (cyc == ready_cyc);
    bus_rsp_valid = (cyc == rsp_cyc) || (cyc == stray_cyc);
    bus_rdata     = (cyc == rsp_cyc) ? plan_word : 32'hDEAD_BEEF;
    bus_rsp_err   = (cyc == rsp_cyc) ? plan_err : (cyc == stray_cyc);
  endtask

  // d: bus_ready delay after bus_valid rises (-1 = never), r: response delay
  // after the handshake (0 = same cycle), rst_at: reset this many cycles
  // after acceptance (-1 = no reset).
  task automatic applyStimulus(input logic wen, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] word, input int d, input int r,
                               input logic rerr, input int rst_at);
    int size, off, c0;
    logic legal, rejected, timeout;
    longint v, span;
    for (int i = 0; i < 50 && cyc <= busy_to; i++) step();
    legal = wen ? (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2)
                : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    case (f3)
      3'd1, 3'd5: size = 2;
      3'd2:       size = 4;
      default:    size = 1;
    endcase
    off      = int'(addr % 32'd4);
    rejected = !legal || ((addr % size) != 0);
    timeout  = !rejected && (d < 0);
    exp_addr  = addr - off;
    exp_wen   = wen;
    exp_wstrb = wen ? 4'(((1 << size) - 1) << off) : 4'd0;
    exp_wdata = (size == 1) ? {24'd0, wdata[7:0]} * 32'h0101_0101 :
                (size == 2) ? {16'd0, wdata[15:0]} * 32'h0001_0001 : wdata;
    span = longint'(1) << (8 * size);
    v    = (longint'(word) >> (8 * off)) % span;
    if ((f3 == 3'd0 || f3 == 3'd1) && v >= span / 2) v = v - span;
    exp_err   = rejected || timeout || rerr;
    exp_rdata = (exp_err || wen) ? 32'd0 : 32'(v);
    c0 = cyc;
    if (rejected) begin
      bv_from = -1; bv_to = -2; ready_cyc = -1; rsp_cyc = -1; resp_at = c0 + 1;
    end else if (timeout) begin
      bv_from = c0 + 1; bv_to = c0 + TB_TIMEOUT; ready_cyc = -1; rsp_cyc = -1;
      resp_at = c0 + TB_TIMEOUT + 1;
    end else begin
      ready_cyc = c0 + 1 + d; rsp_cyc = ready_cyc + r;
      bv_from = c0 + 1; bv_to = ready_cyc; resp_at = rsp_cyc + 1;
    end
    busy_from = c0 + 1;
    busy_to   = resp_at;
    plan_word = word;
    plan_err  = rerr;
    req_valid = 1'b1; req_wen = wen; req_func3 = f3; req_addr = addr; req_wdata = wdata;
    step();
    req_valid = 1'b0; req_wen = ~wen; req_func3 = 3'b111;
    req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5A5A_5A5A;
    for (int i = 0; i < 400 && cyc <= resp_at; i++) begin
      if (rst_at >= 0 && cyc == c0 + rst_at) begin
        rst_n = 1'b0;
        busy_to = cyc; resp_at = -1; rsp_cyc = cyc + 1; zero_chk = cyc + 1;
        step();
        rst_n = 1'b1;
        step();
        step();
        break;
      end
      step();
    end
    lit_rdata_en = 1'b0;
    lit_bus_en   = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_wen = 1'b0; req_func3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0;
    bus_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rdata = 32'd0; bus_rsp_err = 1'b0;
    step();
    checking = 1'b1;
    zero_chk = cyc;
    step();
    rst_n = 1'b1;
    step();

    // LB / LBU of the top byte, zero-wait bus
    lit_rdata_en = 1'b1; lit_rdata = 32'hFFFF_FF80;
    applyStimulus(1'b0, 3'b000, 32'h8000_0003, 32'd0, 32'h80FF_FF7F, 0, 0, 1'b0, -1);
    lit_rdata_en = 1'b1; lit_rdata = 32'h0000_0080;
    applyStimulus(1'b0, 3'b100, 32'h8000_0003, 32'd0, 32'h80FF_FF7F, 0, 0, 1'b0, -1);

    // SH to the upper half
    lit_bus_en = 1'b1; lit_addr = 32'h8000_0000; lit_wstrb = 4'b1100; lit_wdata = 32'hABCD_ABCD;
    lit_rdata_en = 1'b1; lit_rdata = 32'd0;
    applyStimulus(1'b1, 3'b001, 32'h8000_0002, 32'h1234_ABCD, 32'hFFFF_FFFF, 0, 0, 1'b0, -1);

    // misaligned LW: rejected without a bus access
    lit_rdata_en = 1'b1; lit_rdata = 32'd0;
    applyStimulus(1'b0, 3'b010, 32'h8000_0001, 32'd0, 32'h1111_1111, 0, 0, 1'b0, -1);

    // LH with slow handshake and slow response
    lit_rdata_en = 1'b1; lit_rdata = 32'hFFFF_8001;
    applyStimulus(1'b0, 3'b001, 32'h8000_0002, 32'd0, 32'h8001_1234, 3, 2, 1'b0, -1);

    // reset while in WAIT, late response must be ignored
    applyStimulus(1'b0, 3'b010, 32'h8000_0010, 32'd0, 32'h7777_7777, 0, 1000, 1'b0, 3);

    // next request after reset completes normally
    lit_rdata_en = 1'b1; lit_rdata = 32'hCAFE_F00D;
    applyStimulus(1'b0, 3'b010, 32'h8000_0010, 32'd0, 32'hCAFE_F00D, 1, 1, 1'b0, -1);

    // SB at offset 1
    lit_bus_en = 1'b1; lit_addr = 32'h8000_0000; lit_wstrb = 4'b0010; lit_wdata = 32'hA5A5_A5A5;
    applyStimulus(1'b1, 3'b000, 32'h8000_0001, 32'h0000_00A5, 32'd0, 0, 2, 1'b0, -1);

    // SW with bus error
    applyStimulus(1'b1, 3'b010, 32'h8000_0004, 32'h1122_3344, 32'd0, 2, 0, 1'b1, -1);

    // illegal funct3 for a load and for a store
    applyStimulus(1'b0, 3'b011, 32'h8000_0008, 32'd0, 32'd0, 0, 0, 1'b0, -1);
    applyStimulus(1'b1, 3'b100, 32'h8000_0008, 32'h0000_00FF, 32'd0, 0, 0, 1'b0, -1);

    // LHU at offset 0, LB with bus error
    lit_rdata_en = 1'b1; lit_rdata = 32'h0000_F00F;
    applyStimulus(1'b0, 3'b101, 32'h8000_0000, 32'd0, 32'h1234_F00F, 0, 3, 1'b0, -1);
    applyStimulus(1'b0, 3'b000, 32'h8000_0001, 32'd0, 32'h0000_8000, 1, 0, 1'b1, -1);

    // stray response while idle
    stray_cyc = cyc + 1;
    step();
    step();
    step();

    // LBU at offset 2, back-to-back after the previous access
    lit_rdata_en = 1'b1; lit_rdata = 32'h0000_00AB;
    applyStimulus(1'b0, 3'b100, 32'h8000_0006, 32'd0, 32'h00AB_0000, 0, 0, 1'b0, -1);

`ifdef LSU_TIMEOUT_EN
    // bus never ready: watchdog ends the access with an error
    applyStimulus(1'b0, 3'b010, 32'h8000_0020, 32'd0, 32'd0, -1, 0, 1'b0, -1);
`endif

    step();
    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lsu_mem.md
# lsu_mem

Load/store unit for the multicycle core, sitting directly downstream of the write-back stage. It consumes the memory address, store data and access type that write-back produces and performs one data-memory transaction over a simple valid/ready bus. It returns aligned, sign- or zero-extended load data, or a store acknowledgement, and raises the `mem_finish`-style completion pulse the control FSM waits on. One transaction is outstanding at a time.

## Interface
- `TIMEOUT_CYCLES`, default 255: watchdog limit in WAIT. Used only with `LSU_TIMEOUT_EN`.
- `clk  in  1`: single clock, rising edge.
- `rst_n  in  1`: reset, synchronous, active-low.
- `req_valid  in  1`: access request from write-back.
- `req_ready  out  1`: LSU can accept a request.
- `req_wen  in  1`: 1 = store, 0 = load.
- `req_func3  in  3`: RISC-V funct3 access size and sign.
- `req_addr  in  32`: byte address, i.e. `mem_raddr` / `mem_waddr`.
- `req_wdata  in  32`: store data (rs2).
- `resp_valid  out  1`: one-cycle completion pulse.
- `resp_rdata  out  32`: extended load data; 0 for stores.
- `resp_err  out  1`: misaligned, illegal funct3, bus error or timeout. Qualified by `resp_valid`.
- `bus_valid  out  1`: bus request.
- `bus_ready  in  1`: bus accepts the request.
- `bus_wen  out  1`: write request.
- `bus_addr  out  32`: word-aligned address, `{req_addr[31:2],2'b00}`.
- `bus_wdata  out  32`: lane-replicated store data.
- `bus_wstrb  out  4`: byte strobes; 0 for reads.
- `bus_rsp_valid  in  1`: bus response, for both reads and writes.
- `bus_rdata  in  32`: read word.
- `bus_rsp_err  in  1`: bus error, qualified by `bus_rsp_valid`.

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, latch `wen`, `func3`, `addr` and `wdata`.
  - Check the access. Misaligned means a halfword with `addr[0]`=1, or a word with `addr[1:0]`≠0. Illegal funct3 means loads other than 000/001/010/100/101, or stores other than 000/001/010.
  - If the check fails, go to RESP with err=1 and make no bus access. Otherwise go to REQ.
- REQ:
  - `bus_valid`=1 and all bus outputs are held stable until `bus_ready`.
  - On handshake, go to WAIT.
  - If `bus_rsp_valid` arrives in the same cycle as the handshake, go directly to RESP and capture the response.
- WAIT: on `bus_rsp_valid`, capture `bus_rdata` and `bus_rsp_err`, then go to RESP.
- RESP: `resp_valid`=1 for exactly one cycle, then go to IDLE.
- Store strobes and data, using offset o = `addr[1:0]`:
  - SB: wstrb=`4'b0001<<o`, wdata={4{wdata[7:0]}}.
  - SH: wstrb=`4'b0011<<o`, wdata={2{wdata[15:0]}}.
  - SW: wstrb=`4'hF`.
- Load data: extract the byte or halfword at offset o from `bus_rdata`.
  - LB/LH sign-extend.
  - LBU/LHU zero-extend.
  - LW passes the word through.
- `bus_rsp_valid` outside REQ/WAIT is ignored.
- On any error, `resp_rdata`=0.

## Timing
- Reset: with `rst_n` low at an edge, the FSM goes to IDLE at that edge.
  - All outputs become 0 except `req_ready`=1.
  - All latched fields are cleared.
  - Reset mid-transaction abandons it, and any late bus response is ignored.
- Request accepted at cycle 0 (IDLE, valid&ready):
  - `bus_valid` at cycle 1.
  - With `bus_ready` and `bus_rsp_valid` both at cycle 1: `resp_valid` at cycle 2. This is the minimum latency for a bus access.
  - With `bus_ready` at cycle 1 and the response at cycle k ≥ 2: `resp_valid` at cycle k+1.
- Rejected access (misaligned or illegal funct3): `resp_valid` with err at cycle 1.
- `req_ready`=0 in REQ, WAIT and RESP, so a new request can be accepted at the earliest in the cycle after RESP.
- Outputs are registered: `resp_*` and `bus_*` are driven from state and latched registers, with no combinational path from `bus_*` inputs.

## Configuration
- `LSU_TIMEOUT_EN`, when defined:
  - An 8+ bit counter clears on entry to REQ and increments each cycle in REQ or WAIT.
  - When it reaches `TIMEOUT_CYCLES`, the FSM goes to RESP with err=1 and drops `bus_valid`.
  - A later bus response is ignored.
- When undefined: no counter, and the unit waits indefinitely.

## Structure
- Shared package `lsu_pkg`:
  - State enum `lsu_state_t`.
  - funct3 constants `F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`.
  - Opcode macros reuse the existing `OPCODE_LOAD` / `OPCODE_STORE` definitions.
- Sub-module `lsu_align`, purely combinational:
  - Inputs: func3, offset, rdata, wdata.
  - Outputs: extended load data, wstrb, replicated wdata, misaligned flag.
- Top: FSM, latches and timeout.

## Test plan
- LB at 0x8000_0003, bus returns 0x80FF_FF7F with zero-wait handshake → `resp_valid` at cycle 2, rdata=0xFFFF_FF80, err=0. Same access as LBU → 0x0000_0080.
- SH at 0x8000_0002 with wdata=0x1234_ABCD → `bus_wstrb`=4'b1100, `bus_wdata`=0xABCD_ABCD, `bus_addr`=0x8000_0000.
- LW at 0x8000_0001 → `resp_valid` at cycle 1 with err=1, rdata=0 and no `bus_valid` pulse.
- LH with `bus_ready` delayed 3 cycles and response 2 cycles after that → `bus_*` outputs stable throughout, `resp_valid` a single pulse, `req_ready` back to 1 the cycle after.
- `rst_n` low while in WAIT, then response pulse → no `resp_valid`, state IDLE, next request completes normally.
- With `LSU_TIMEOUT_EN` and `TIMEOUT_CYCLES`=8, bus never ready → `resp_valid` with err=1 after 8 cycles in REQ, `bus_valid`=0 afterwards.
